// File: rtl/scan_pkg.sv
// Shared FSM state and scan-mode encodings for the scan index generator.
package scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PING = 2'b10;
  localparam logic [1:0] MODE_ONCE = 2'b11;

endpackage

// File: rtl/scan_prescaler.sv
// Dwell prescaler: tick every div+1 enabled cycles; tick is combinational from the count.
// load captures div and restarts; hold freezes the count; clear zeroes it (highest priority).
module scan_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             hold,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;

  assign tick = !clear && !load && !hold && (cnt == div_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      div_q <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt   <= '0;
      div_q <= div;
    end else if (!hold) begin
      cnt <= tick ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/scan_index_gen.sv
// Registered 5-bit scan index generator (up/down/ping-pong/single-shot) with dwell and pause.
// Build option SCAN_BLANK_ON_HOLD_EN: drive en low while paused in HOLD.
module scan_index_gen
  import scan_pkg::*;
#(
  parameter int LAST_IDX = 31,
  parameter int DIV_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  output logic [4:0]       x,
  output logic             en,
  output logic             busy,
  output logic             wrap,
  output logic             done
);

  localparam logic [4:0] LAST = LAST_IDX[4:0];
`ifdef SCAN_BLANK_ON_HOLD_EN
  localparam logic HOLD_EN = 1'b0;
`else
  localparam logic HOLD_EN = 1'b1;
`endif

  state_t     state;
  logic [1:0] mode_q;
  logic       dir_dn;
  logic       tick;
  logic       launch;

  assign launch = (state == S_IDLE) && start && !stop;

  // The dwell count only advances while scanning and not paused, so a pause
  // of N cycles stretches the current index by exactly N.
  scan_prescaler #(.DIV_W(DIV_W)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (launch),
    .hold  ((state == S_IDLE) || pause),
    .clear (stop),
    .div   (div),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      x      <= '0;
      en     <= 1'b0;
      busy   <= 1'b0;
      wrap   <= 1'b0;
      done   <= 1'b0;
      mode_q <= MODE_UP;
      dir_dn <= 1'b0;
    end else begin
      wrap <= 1'b0;
      done <= 1'b0;
      if (stop) begin
        state <= S_IDLE;
        en    <= 1'b0;
        busy  <= 1'b0;
      end else if (state == S_IDLE) begin
        if (start) begin
          state  <= S_RUN;
          en     <= 1'b1;
          busy   <= 1'b1;
          mode_q <= mode;
          dir_dn <= 1'b0;
          x      <= (mode == MODE_DOWN) ? LAST : 5'd0;
        end
      end else if (tick && (mode_q == MODE_ONCE) && (x == LAST)) begin
        state <= S_IDLE;
        en    <= 1'b0;
        busy  <= 1'b0;
        done  <= 1'b1;
      end else begin
        if (pause) begin
          state <= S_HOLD;
          en    <= HOLD_EN;
        end else begin
          state <= S_RUN;
          en    <= 1'b1;
        end
        if (tick) begin
          case (mode_q)
            MODE_UP: begin
              if (x == LAST) begin
                x    <= 5'd0;
                wrap <= 1'b1;
              end else begin
                x <= x + 5'd1;
              end
            end
            MODE_DOWN: begin
              if (x == 5'd0) begin
                x    <= LAST;
                wrap <= 1'b1;
              end else begin
                x <= x - 5'd1;
              end
            end
            MODE_PING: begin
              // Turn around without repeating the endpoint; LAST=1 lands straight on 0.
              if (!dir_dn) begin
                if (x == LAST) begin
                  x <= LAST - 5'd1;
                  if (LAST == 5'd1) begin
                    wrap <= 1'b1;
                  end else begin
                    dir_dn <= 1'b1;
                  end
                end else begin
                  x <= x + 5'd1;
                end
              end else begin
                x <= x - 5'd1;
                if (x == 5'd1) begin
                  wrap   <= 1'b1;
                  dir_dn <= 1'b0;
                end
              end
            end
            default: x <= x + 5'd1;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_scan_index_gen.sv
// Directed self-checking bench for scan_index_gen (LAST_IDX=31 and LAST_IDX=3 instances).
module tb_scan_index_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, pause;
  logic [1:0] mode;
  logic [7:0] div;
  logic [4:0] a_x, b_x;
  logic       a_en, a_busy, a_wrap, a_done;
  logic       b_en, b_busy, b_wrap, b_done;

  int tests = 0;
  int fails = 0;

`ifdef SCAN_BLANK_ON_HOLD_EN
  localparam logic EXP_HOLD_EN = 1'b0;
`else
  localparam logic EXP_HOLD_EN = 1'b1;
`endif

  always #5 clk = ~clk;

  scan_index_gen #(.LAST_IDX(31), .DIV_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
    .mode(mode), .div(div), .x(a_x), .en(a_en), .busy(a_busy),
    .wrap(a_wrap), .done(a_done)
  );

  scan_index_gen #(.LAST_IDX(3), .DIV_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
    .mode(mode), .div(div), .x(b_x), .en(b_en), .busy(b_busy),
    .wrap(b_wrap), .done(b_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int ping_exp [12] = '{1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1, 0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
    mode = 2'b00; div = 8'd0;
    #12;
    chk("rst_x", 32'(a_x), 0);
    chk("rst_en", 32'(a_en), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_wrap", 32'(a_wrap), 0);
    chk("rst_done", 32'(a_done), 0);
    rst_n = 1'b1;
    repeat (3) step();
    chk("post_rst_idle_busy", 32'(a_busy), 0);
    chk("post_rst_idle_en", 32'(a_en), 0);

    // Up mode, div=0: 0..31 then wrap to 0
    mode = 2'b00; div = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("up_first_x", 32'(a_x), 0);
    chk("up_first_en", 32'(a_en), 1);
    chk("up_first_busy", 32'(a_busy), 1);
    chk("up_first_wrap", 32'(a_wrap), 0);
    for (int i = 1; i <= 31; i++) begin
      step();
      chk("up_x", 32'(a_x), 32'(i));
      chk("up_nowrap", 32'(a_wrap), 0);
    end
    step();
    chk("up_wrap_x", 32'(a_x), 0);
    chk("up_wrap_pulse", 32'(a_wrap), 1);
    step();
    chk("up_after_wrap_x", 32'(a_x), 1);
    chk("up_after_wrap_pulse", 32'(a_wrap), 0);

    // Asynchronous reset mid-scan at x=17
    repeat (16) step();
    chk("pre_rst_x", 32'(a_x), 17);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_x", 32'(a_x), 0);
    chk("async_rst_en", 32'(a_en), 0);
    chk("async_rst_busy", 32'(a_busy), 0);
    #3 rst_n = 1'b1;
    repeat (2) step();
    chk("rst_no_scan_busy", 32'(a_busy), 0);
    chk("rst_no_scan_x", 32'(a_x), 0);

    // Down mode, div=3, with late mode/div changes, ignored start and a 5-cycle pause
    mode = 2'b01; div = 8'd3; start = 1'b1;
    step();
    start = 1'b0; mode = 2'b00; div = 8'd0;
    chk("dn_first_x", 32'(a_x), 31);
    step(); chk("dn_dwell1", 32'(a_x), 31);
    step(); chk("dn_dwell2", 32'(a_x), 31);
    start = 1'b1;
    step(); chk("dn_start_ignored", 32'(a_x), 31);
    start = 1'b0;
    step(); chk("dn_step30", 32'(a_x), 30);
    step(); step();
    chk("dn_mid_dwell", 32'(a_x), 30);
    pause = 1'b1;
    step();
    chk("hold_x", 32'(a_x), 30);
    chk("hold_busy", 32'(a_busy), 1);
    chk("hold_en", 32'(a_en), 32'(EXP_HOLD_EN));
    repeat (4) step();
    chk("hold_end_x", 32'(a_x), 30);
    chk("hold_end_en", 32'(a_en), 32'(EXP_HOLD_EN));
    pause = 1'b0;
    step();
    chk("resume_x", 32'(a_x), 30);
    chk("resume_en", 32'(a_en), 1);
    step();
    chk("dn_step29", 32'(a_x), 29);

    // Stop during HOLD
    pause = 1'b1;
    step();
    chk("hold2_busy", 32'(a_busy), 1);
    chk("hold2_en", 32'(a_en), 32'(EXP_HOLD_EN));
    stop = 1'b1;
    step();
    chk("stop_hold_busy", 32'(a_busy), 0);
    chk("stop_hold_en", 32'(a_en), 0);
    chk("stop_hold_x", 32'(a_x), 29);
    stop = 1'b0; pause = 1'b0;
    step();
    chk("stop_stays_idle", 32'(a_busy), 0);

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("start_stop_busy", 32'(a_busy), 0);
    chk("start_stop_en", 32'(a_en), 0);
    chk("start_stop_x", 32'(a_x), 29);
    step();
    chk("start_stop_later_busy", 32'(a_busy), 0);

    // Ping-pong on the LAST_IDX=3 instance
    mode = 2'b10; div = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("ping_first_x", 32'(b_x), 0);
    chk("ping_first_busy", 32'(b_busy), 1);
    chk("ping_first_en", 32'(b_en), 1);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("ping_x", 32'(b_x), 32'(ping_exp[i]));
      chk("ping_wrap", 32'(b_wrap), (ping_exp[i] == 0) ? 1 : 0);
      chk("ping_nodone", 32'(b_done), 0);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("ping_stopped", 32'(b_busy), 0);

    // Single-shot, div=1: 64 RUN cycles then done
    mode = 2'b11; div = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    chk("once_first_x", 32'(a_x), 0);
    for (int i = 1; i < 64; i++) begin
      step();
      chk("once_x", 32'(a_x), 32'(i / 2));
      chk("once_busy", 32'(a_busy), 1);
      chk("once_nodone", 32'(a_done), 0);
      chk("once_nowrap", 32'(a_wrap), 0);
    end
    step();
    chk("once_done", 32'(a_done), 1);
    chk("once_en", 32'(a_en), 0);
    chk("once_busy_end", 32'(a_busy), 0);
    chk("once_x_end", 32'(a_x), 31);
    step();
    chk("once_done_pulse", 32'(a_done), 0);
    chk("once_x_stays", 32'(a_x), 31);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scan_index_gen.md
SCAN_INDEX_GEN -- requirements
Module: scan_index_gen

Interface
REQ-001 Parameter: LAST_IDX, 31, highest index emitted; legal range 1..31.
REQ-002 Parameter: DIV_W, 8, width of dwell divider input.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: start  input  1  start request, sampled each cycle.
REQ-006 Port: stop  input  1  stop request, sampled each cycle.
REQ-007 Port: pause  input  1  level; freezes scanning while high.
REQ-008 Port: mode  input  2  00 up, 01 down, 10 ping-pong, 11 single-shot up.
REQ-009 Port: div  input  DIV_W  dwell per index = div+1 cycles.
REQ-010 Port: x  output  5  index to the 5-to-32 decoder, registered.
REQ-011 Port: en  output  1  decoder enable, registered.
REQ-012 Port: busy  output  1  high in RUN or HOLD.
REQ-013 Port: wrap  output  1  one-cycle pulse on sequence wrap.
REQ-014 Port: done  output  1  one-cycle pulse at single-shot completion.

Function
REQ-015 FSM states IDLE, RUN, HOLD; IDLE after reset.
REQ-016 IDLE + start (stop low): next cycle RUN, en=1, x=LAST_IDX for mode 01, else x=0; mode and div captured, later changes ignored until next start.
REQ-017 start in RUN or HOLD is ignored.
REQ-018 stop in any state: next cycle IDLE, en=0, x holds its value, dwell counter cleared; stop wins over simultaneous start or pause.
REQ-019 RUN: each index held exactly div+1 cycles; div=0 advances every cycle.
REQ-020 Up: x increments; LAST_IDX -> 0 with wrap pulse in the cycle x becomes 0.
REQ-021 Down: x decrements; 0 -> LAST_IDX with wrap pulse in the cycle x becomes LAST_IDX.
REQ-022 Ping-pong: 0..LAST_IDX..0 with no repeated endpoint; wrap pulses in the cycle x returns to 0.
REQ-023 Single-shot: 0..LAST_IDX; when LAST_IDX dwell expires -> IDLE, en=0, done pulse same cycle, x stays LAST_IDX.
REQ-024 RUN + pause high -> HOLD next cycle; dwell counter and x frozen; pause low -> RUN, dwell resumes from frozen count.
REQ-025 busy = 1 exactly in RUN/HOLD; wrap and done never high outside the stated cycles.

Reset
REQ-026 rst_n low immediately forces IDLE, x=0, en=0, busy=0, wrap=0, done=0, dwell counter=0, including mid-scan.
REQ-027 After rst_n rises, no scan occurs until a new start.

Configuration
REQ-028 SCAN_BLANK_ON_HOLD_EN defined: en=0 in HOLD, restored to 1 on return to RUN.
REQ-029 SCAN_BLANK_ON_HOLD_EN undefined: en stays 1 in HOLD; all other behaviour identical.

Structure
REQ-030 Package scan_pkg holds FSM state enum and mode encodings (MODE_UP, MODE_DOWN, MODE_PING, MODE_ONCE).
REQ-031 Dwell counting in sub-module scan_prescaler (load, hold, clear inputs; tick output).
REQ-032 All outputs driven directly from flops; no combinational start-to-output path.

Verification
REQ-033 Reset mid-scan: mode 00, div=0, rst_n low at x=17 -> x=0, en=0, busy=0 same cycle without clock.
REQ-034 Up wrap: mode 00, div=0, LAST_IDX=31 -> x 0..31,0; wrap high only in the cycle x=0 after 31.
REQ-035 Dwell: mode 01, div=3 -> x 31 for 4 cycles, 30 for 4 cycles; pause 5 cycles mid-dwell extends that index by exactly 5.
REQ-036 Ping-pong LAST_IDX=3, div=0 -> x 0,1,2,3,2,1,0,1; wrap on each return to 0.
REQ-037 Single-shot div=1, LAST_IDX=31 -> 64 RUN cycles then done pulse, en=0, busy=0, x=31.
REQ-038 start and stop same cycle in IDLE -> remains IDLE, en=0; stop during HOLD -> IDLE next cycle; HOLD en checked with and without SCAN_BLANK_ON_HOLD_EN.
